// File: rtl/adsr_env.sv
// rtl/adsr_env.sv - per-voice ADSR envelope generator
// Gate edges start attack/release; a per-phase prescaler paces the 8-bit envelope steps.
module adsr_env #(
   parameter int BASE_PERIOD = 9,
   parameter int CNT_W       = 24
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       gate,
   input  logic [3:0] attack_rate,
   input  logic [3:0] decay_rate,
   input  logic [3:0] sustain_lvl,
   input  logic [3:0] release_rate,
   output logic [7:0] envelope,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_ATTACK  = 3'd1,
      S_DECAY   = 3'd2,
      S_SUSTAIN = 3'd3,
      S_RELEASE = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           st_q, st_d;
   logic [7:0]       env_q, env_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] period;
   logic [3:0]       rate;
   logic [7:0]       sus8;
   logic             gate_q;
   logic             rise, fall;
   logic             gated_phase, edge_evt;
   logic             active, tick;

   assign rise        = gate & ~gate_q;
   assign fall        = ~gate & gate_q;
   assign sus8        = {sustain_lvl, sustain_lvl};
   assign gated_phase = (st_q == S_ATTACK) || (st_q == S_DECAY) || (st_q == S_SUSTAIN);
   // A gate edge overrides any tick or level transition in the same cycle.
   assign edge_evt    = rise | (fall & gated_phase);
   assign active      = (st_q == S_ATTACK) || (st_q == S_DECAY) || (st_q == S_RELEASE);

   always_comb begin
      rate = 4'd0;
      case (st_q)
         S_ATTACK:  rate = attack_rate;
         S_DECAY:   rate = decay_rate;
         S_RELEASE: rate = release_rate;
         default:   rate = 4'd0;
      endcase
   end

   // Rates are live, so a lowered rate mid-count ticks on the next edge via >=.
   assign period = CNT_W'(BASE_PERIOD) << rate;
   assign tick   = active && (cnt_q >= (period - CNT_ONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st_q   <= S_IDLE;
         env_q  <= 8'd0;
         cnt_q  <= '0;
         gate_q <= 1'b0;
      end else begin
         st_q   <= st_d;
         env_q  <= env_d;
         cnt_q  <= cnt_d;
         gate_q <= gate;
      end
   end

   always_comb begin
      st_d = st_q;
      if (rise) begin
         st_d = S_ATTACK;
      end else if (fall && gated_phase) begin
         st_d = S_RELEASE;
      end else begin
         case (st_q)
            S_ATTACK:  if (tick && (env_q >= 8'd254)) st_d = S_DECAY;
            S_DECAY:   if (env_q <= sus8) st_d = S_SUSTAIN;
            S_SUSTAIN: if (sus8 < env_q) st_d = S_DECAY;
            S_RELEASE: if (env_q == 8'd0) st_d = S_IDLE;
            default:   st_d = st_q;
         endcase
      end
   end

   always_comb begin
      env_d = env_q;
      cnt_d = '0;
      if ((st_d == st_q) && active) begin
         cnt_d = tick ? '0 : (cnt_q + CNT_ONE);
      end
      if (!edge_evt) begin
         case (st_q)
            S_IDLE:    env_d = 8'd0;
            S_ATTACK:  if (tick && (env_q != 8'hFF)) env_d = env_q + 8'd1;
            S_DECAY:   if (tick && (env_q > sus8)) env_d = env_q - 8'd1;
            S_RELEASE: if (tick && (env_q != 8'd0)) env_d = env_q - 8'd1;
            default:   env_d = env_q;
         endcase
      end
   end

   assign envelope = env_q;
   assign state    = st_q;

endmodule

// File: tb/tb_adsr_env.sv
// tb/tb_adsr_env.sv - bench for adsr_env with BASE_PERIOD=2
// Directed phase scenarios plus a randomized run against an edge-by-edge reference model.
module tb_adsr_env;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       gate = 1'b0;
   logic [3:0] attack_rate = 4'd0;
   logic [3:0] decay_rate = 4'd0;
   logic [3:0] sustain_lvl = 4'd15;
   logic [3:0] release_rate = 4'd0;
   logic [7:0] envelope;
   logic [2:0] state;

   int total = 0;
   int bad = 0;

   adsr_env #(.BASE_PERIOD(2), .CNT_W(24)) dut (
      .clk(clk),
      .rst_n(rst_n),
      .gate(gate),
      .attack_rate(attack_rate),
      .decay_rate(decay_rate),
      .sustain_lvl(sustain_lvl),
      .release_rate(release_rate),
      .envelope(envelope),
      .state(state)
   );

   always #5 clk = ~clk;

   // Reference model: phases as small integers, steps counted in edges since phase entry.
   int m_env = 0;
   int m_st = 0;
   int m_since = 0;
   bit m_gprev = 1'b0;
   bit m_rise, m_fall;
   int m_per, m_old, m_sus, m_r;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_env = 0; m_st = 0; m_since = 0; m_gprev = 1'b0;
      end else begin
         m_rise = gate && !m_gprev;
         m_fall = !gate && m_gprev;
         m_gprev = gate;
         m_old = m_st;
         m_sus = 17 * int'(sustain_lvl);
         m_r = (m_st == 1) ? int'(attack_rate) : (m_st == 2) ? int'(decay_rate) : int'(release_rate);
         m_per = 2 * (1 << m_r);
         m_since = m_since + 1;
         if (m_rise) m_st = 1;
         else if (m_fall && (m_st >= 1) && (m_st <= 3)) m_st = 4;
         else begin
            case (m_st)
               0: m_env = 0;
               1: if (m_since >= m_per) begin
                     m_since = 0;
                     if (m_env < 255) m_env = m_env + 1;
                     if (m_env == 255) m_st = 2;
                  end
               2: if (m_env <= m_sus) m_st = 3;
                  else if (m_since >= m_per) begin m_since = 0; m_env = m_env - 1; end
               3: if (m_sus < m_env) m_st = 2;
               4: if (m_env == 0) m_st = 0;
                  else if (m_since >= m_per) begin m_since = 0; m_env = m_env - 1; end
               default: m_st = 0;
            endcase
         end
         if (m_st != m_old) m_since = 0;
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      gate = 1'b0;
      #2;
      rst_n = 1'b1;
      step(2);
   endtask

   task automatic test_reset();
      #2;
      total++; if (envelope !== 8'd0) begin bad++; $display("FAIL reset_env got=%0d want=0", envelope); end
      total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_state got=%0d want=0", state); end
      #10 rst_n = 1'b1;
      step(1);
      attack_rate = 4'd0;
      gate = 1'b1;
      step(129);
      total++; if (envelope !== 8'h40) begin bad++; $display("FAIL reset_pre_env got=%0d want=64", envelope); end
      #3 rst_n = 1'b0;
      #1;
      total++; if (envelope !== 8'd0) begin bad++; $display("FAIL reset_async_env got=%0d want=0", envelope); end
      total++; if (state !== 3'd0) begin bad++; $display("FAIL reset_async_state got=%0d want=0", state); end
      rst_n = 1'b1;
      step(1);
      total++; if (state !== 3'd1) begin bad++; $display("FAIL reset_gate_high_state got=%0d want=1", state); end
   endtask

   task automatic test_attack();
      do_reset();
      attack_rate = 4'd0; decay_rate = 4'd1; sustain_lvl = 4'd8;
      gate = 1'b1;
      step(1);
      total++; if (state !== 3'd1 || envelope !== 8'd0) begin bad++; $display("FAIL attack_enter got=%0d/%0d want=1/0", state, envelope); end
      step(2);
      total++; if (envelope !== 8'd1) begin bad++; $display("FAIL attack_first_step got=%0d want=1", envelope); end
      step(507);
      total++; if (state !== 3'd1 || envelope !== 8'd254) begin bad++; $display("FAIL attack_k509 got=%0d/%0d want=1/254", state, envelope); end
      step(1);
      total++; if (state !== 3'd2 || envelope !== 8'd255) begin bad++; $display("FAIL attack_top got=%0d/%0d want=2/255", state, envelope); end
   endtask

   task automatic test_decay_sustain();
      step(475);
      total++; if (state !== 3'd2 || envelope !== 8'h89) begin bad++; $display("FAIL decay_pre got=%0d/%0d want=2/137", state, envelope); end
      step(1);
      total++; if (state !== 3'd2 || envelope !== 8'h88) begin bad++; $display("FAIL decay_floor got=%0d/%0d want=2/136", state, envelope); end
      step(1);
      total++; if (state !== 3'd3 || envelope !== 8'h88) begin bad++; $display("FAIL sustain_enter got=%0d/%0d want=3/136", state, envelope); end
      step(20);
      total++; if (state !== 3'd3 || envelope !== 8'h88) begin bad++; $display("FAIL sustain_hold got=%0d/%0d want=3/136", state, envelope); end
      sustain_lvl = 4'd4;
      step(1);
      total++; if (state !== 3'd2) begin bad++; $display("FAIL sustain_lower got=%0d want=2", state); end
      step(300);
      total++; if (state !== 3'd3 || envelope !== 8'h44) begin bad++; $display("FAIL sustain_resettle got=%0d/%0d want=3/68", state, envelope); end
      sustain_lvl = 4'd15;
      step(10);
      total++; if (state !== 3'd3 || envelope !== 8'h44) begin bad++; $display("FAIL sustain_raise got=%0d/%0d want=3/68", state, envelope); end
   endtask

   task automatic test_release();
      do_reset();
      attack_rate = 4'd0; release_rate = 4'd0; sustain_lvl = 4'd15;
      gate = 1'b1;
      step(201);
      total++; if (envelope !== 8'd100) begin bad++; $display("FAIL release_pre got=%0d want=100", envelope); end
      gate = 1'b0;
      step(1);
      total++; if (state !== 3'd4 || envelope !== 8'd100) begin bad++; $display("FAIL release_enter got=%0d/%0d want=4/100", state, envelope); end
      step(199);
      total++; if (envelope !== 8'd1) begin bad++; $display("FAIL release_k400 got=%0d want=1", envelope); end
      step(1);
      total++; if (state !== 3'd4 || envelope !== 8'd0) begin bad++; $display("FAIL release_zero got=%0d/%0d want=4/0", state, envelope); end
      step(1);
      total++; if (state !== 3'd0 || envelope !== 8'd0) begin bad++; $display("FAIL release_idle got=%0d/%0d want=0/0", state, envelope); end
      step(5);
      total++; if (state !== 3'd0 || envelope !== 8'd0) begin bad++; $display("FAIL idle_hold got=%0d/%0d want=0/0", state, envelope); end
   endtask

   task automatic test_retrigger();
      do_reset();
      attack_rate = 4'd0; release_rate = 4'd0;
      gate = 1'b1;
      step(201);
      gate = 1'b0;
      step(101);
      total++; if (state !== 3'd4 || envelope !== 8'd50) begin bad++; $display("FAIL retrig_pre got=%0d/%0d want=4/50", state, envelope); end
      gate = 1'b1;
      step(1);
      total++; if (state !== 3'd1 || envelope !== 8'd50) begin bad++; $display("FAIL retrig_enter got=%0d/%0d want=1/50", state, envelope); end
      step(2);
      total++; if (envelope !== 8'd51) begin bad++; $display("FAIL retrig_step got=%0d want=51", envelope); end
   endtask

   task automatic test_edges();
      do_reset();
      sustain_lvl = 4'd15; attack_rate = 4'd0; decay_rate = 4'd0;
      gate = 1'b1;
      step(511);
      total++; if (state !== 3'd2 || envelope !== 8'd255) begin bad++; $display("FAIL edge_top got=%0d/%0d want=2/255", state, envelope); end
      step(1);
      total++; if (state !== 3'd3 || envelope !== 8'd255) begin bad++; $display("FAIL edge_sustain got=%0d/%0d want=3/255", state, envelope); end
      do_reset();
      gate = 1'b1;
      step(10);
      total++; if (envelope !== 8'd4) begin bad++; $display("FAIL edge_pre got=%0d want=4", envelope); end
      gate = 1'b0;
      step(1);
      total++; if (state !== 3'd4 || envelope !== 8'd4) begin bad++; $display("FAIL edge_fall_tick got=%0d/%0d want=4/4", state, envelope); end
   endtask

   task automatic test_random();
      int errs = 0;
      do_reset();
      for (int i = 0; i < 6000; i++) begin
         if ($urandom_range(0, 149) == 0) gate = ~gate;
         if ($urandom_range(0, 299) == 0) attack_rate = 4'($urandom_range(0, 2));
         if ($urandom_range(0, 299) == 0) decay_rate = 4'($urandom_range(0, 2));
         if ($urandom_range(0, 299) == 0) release_rate = 4'($urandom_range(0, 2));
         if ($urandom_range(0, 199) == 0) sustain_lvl = 4'($urandom_range(0, 15));
         step(1);
         total++;
         if (envelope !== 8'(m_env) || state !== 3'(m_st)) begin
            bad++;
            errs++;
            if (errs <= 10) $display("FAIL random_cycle%0d got=%0d/%0d want=%0d/%0d", i, state, envelope, m_st, m_env);
         end
      end
   endtask

   initial begin
      test_reset();
      test_attack();
      test_decay_sustain();
      test_release();
      test_retrigger();
      test_edges();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
